// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic array sequencer.
package systolic_pkg;

  localparam int N  = 16;
  localparam int DW = 8;
  localparam int AW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_SWITCH,
    S_STREAM,
    S_DRAIN
  } ctrl_state_t;

  typedef logic [N-1:0][DW-1:0] vec_t;

endpackage

// File: rtl/input_skew.sv
// Triangular input skew: lane i is delayed by i cycles, lane 0 passes straight
// through. Each lane carries its own valid so that stale data reads as zero.
module input_skew
  import systolic_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_flush,
  input  logic i_valid,
  input  vec_t i_data,
  output vec_t o_data
);

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    if (gi == 0) begin : g_pass
      assign o_data[0] = i_valid ? i_data[0] : '0;
    end else begin : g_dly
      logic [DW-1:0] r_d [gi];
      logic [gi-1:0] r_v;

      // Shift this lane's data and valid through its gi-deep delay line.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_v <= '0;
          for (int unsigned k = 0; k < gi; k++) r_d[k] <= '0;
        end else if (i_flush) begin
          r_v <= '0;
          for (int unsigned k = 0; k < gi; k++) r_d[k] <= '0;
        end else begin
          r_v[0] <= i_valid;
          r_d[0] <= i_data[gi];
          for (int unsigned k = 1; k < gi; k++) begin
            r_v[k] <= r_v[k-1];
            r_d[k] <= r_d[k-1];
          end
        end
      end

      assign o_data[gi] = r_v[gi-1] ? r_d[gi-1] : '0;
    end
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Tile sequencer for the weight-stationary systolic array: loads weights
// bottom row first, switches, streams skewed activations and drains results.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int DRAIN_MAX = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] num_vecs,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic          w_rd_en,
  output logic [AW-1:0] w_rd_addr,
  input  vec_t          w_rd_data,
  output logic          x_rd_en,
  output logic [AW-1:0] x_rd_addr,
  input  vec_t          x_rd_data,
  output vec_t          sys_weight,
  output logic          sys_new_weight,
  output logic          sys_switch_in,
  output vec_t          sys_input,
  output logic          sys_valid_in,
  input  logic [N-1:0]  sys_valid_out
);

  localparam int WDW = $clog2(DRAIN_MAX + 1);

  ctrl_state_t    r_state;
  logic [AW:0]    r_cnt;
  logic [AW-1:0]  r_nv;
  logic [WDW-1:0] r_wd;
  logic           r_busy, r_done, r_timeout;
  logic           r_w_en, r_w_pass, r_new_w, r_switch;
  logic [AW-1:0]  r_w_addr;
  logic           r_x_en, r_x_vld;
  logic [AW-1:0]  r_x_addr;
  logic           w_flush;
  logic           w_unused_vo;

  assign w_flush     = abort;
  assign w_unused_vo = ^sys_valid_out[N-2:0];

  // Tile sequencer; every strobe is a register updated with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_nv      <= '0;
      r_wd      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_w_en    <= 1'b0;
      r_w_pass  <= 1'b0;
      r_new_w   <= 1'b0;
      r_switch  <= 1'b0;
      r_w_addr  <= '0;
      r_x_en    <= 1'b0;
      r_x_vld   <= 1'b0;
      r_x_addr  <= '0;
    end else begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_new_w   <= 1'b0;
      r_x_vld   <= r_x_en;
      if (abort) begin
        r_state  <= S_IDLE;
        r_busy   <= 1'b0;
        r_cnt    <= '0;
        r_wd     <= '0;
        r_w_en   <= 1'b0;
        r_w_pass <= 1'b0;
        r_switch <= 1'b0;
        r_w_addr <= '0;
        r_x_en   <= 1'b0;
        r_x_vld  <= 1'b0;
        r_x_addr <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (num_vecs == '0) begin
                r_done <= 1'b1;
              end else begin
                r_nv     <= num_vecs;
                r_state  <= S_LOAD_W;
                r_busy   <= 1'b1;
                r_cnt    <= '0;
                r_w_en   <= 1'b1;
                r_w_addr <= AW'(N - 1);
              end
            end
          end
          S_LOAD_W: begin
            // Reads issue at c=0..N-1, data is forwarded at c=1..N.
            r_cnt   <= r_cnt + 1'b1;
            r_new_w <= (r_cnt == '0);
            if (r_cnt == '0) r_w_pass <= 1'b1;
            if (r_cnt == (AW+1)'(N - 1)) begin
              r_w_en   <= 1'b0;
              r_w_addr <= '0;
            end else if (r_w_en) begin
              r_w_addr <= r_w_addr - 1'b1;
            end
            if (r_cnt == (AW+1)'(N)) begin
              r_state  <= S_SWITCH;
              r_w_pass <= 1'b0;
              r_switch <= 1'b1;
              r_cnt    <= '0;
            end
          end
          S_SWITCH: begin
            r_switch <= 1'b0;
            r_state  <= S_STREAM;
            r_x_en   <= 1'b1;
            r_x_addr <= '0;
            r_cnt    <= '0;
          end
          S_STREAM: begin
            if (r_cnt + 1'b1 == {1'b0, r_nv}) begin
              r_state  <= S_DRAIN;
              r_x_en   <= 1'b0;
              r_x_addr <= '0;
              r_cnt    <= '0;
              r_wd     <= '0;
            end else begin
              r_cnt    <= r_cnt + 1'b1;
              r_x_addr <= r_x_addr + 1'b1;
            end
          end
          S_DRAIN: begin
            if (sys_valid_out[N-1] && (r_cnt + 1'b1 == {1'b0, r_nv})) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_cnt   <= '0;
              r_wd    <= '0;
            end else if (r_wd == WDW'(DRAIN_MAX - 1)) begin
              r_done    <= 1'b1;
              r_timeout <= 1'b1;
              r_state   <= S_IDLE;
              r_busy    <= 1'b0;
              r_cnt     <= '0;
              r_wd      <= '0;
            end else begin
              if (sys_valid_out[N-1]) r_cnt <= r_cnt + 1'b1;
              r_wd <= r_wd + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  input_skew u_skew (
    .clk    (clk),
    .rst    (rst),
    .i_flush(w_flush),
    .i_valid(r_x_vld),
    .i_data (x_rd_data),
    .o_data (sys_input)
  );

  assign busy           = r_busy;
  assign done           = r_done;
  assign timeout        = r_timeout;
  assign w_rd_en        = r_w_en;
  assign w_rd_addr      = r_w_addr;
  assign x_rd_en        = r_x_en;
  assign x_rd_addr      = r_x_addr;
  assign sys_weight     = r_w_pass ? w_rd_data : '0;
  assign sys_new_weight = r_new_w;
  assign sys_switch_in  = r_switch;
  assign sys_valid_in   = r_x_vld;

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
- Sequencer for the 16x16 weight-stationary systolic array. It runs one tile per `start`.
- Per tile: fetch 16 weight rows from the weight buffer and shift them into the array, pulse the array's weight switch, then stream `num_vecs` activation vectors with per-row input skew.
- It then drains until every result has left the bottom row, and pulses `done`.
- It sits between the tile scheduler (start/done) and the array plus its weight/activation buffers.

Parameters:
- N, 16, array dimension (rows = columns = N).
- DW, 8, activation/weight element width.
- AW, 8, buffer address width; also the width of `num_vecs`.
- DRAIN_MAX, 255, watchdog limit in cycles for the DRAIN state.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  tile request; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE with no `done`.
- num_vecs  in  AW  activation vector count; latched on an accepted `start`.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at tile completion.
- timeout  out  1  one-cycle pulse when the DRAIN watchdog expires; asserted together with `done`.
- w_rd_en  out  1  weight buffer read strobe.
- w_rd_addr  out  AW  weight row address.
- w_rd_data  in  N x DW  weight row; valid 1 cycle after `w_rd_en`.
- x_rd_en  out  1  activation buffer read strobe.
- x_rd_addr  out  AW  activation vector address.
- x_rd_data  in  N x DW  activation vector; valid 1 cycle after `x_rd_en`.
- sys_weight  out  N x DW  to array top edge.
- sys_new_weight  out  1  to array; marks the first weight row of a load.
- sys_switch_in  out  1  to array top-left PE.
- sys_input  out  N x DW  to array left edge, skewed.
- sys_valid_in  out  1  to array top-left PE.
- sys_valid_out  in  N  from array bottom row.

Behaviour:
- Reset (`rst`=0): state IDLE, all counters 0, skew registers 0, every output 0.
- States: IDLE, LOAD_W, SWITCH, STREAM, DRAIN.
- IDLE
  - `start`=1 and `num_vecs`>0: latch `num_vecs`, go to LOAD_W.
  - `start`=1 and `num_vecs`=0: pulse `done` next cycle, no array or buffer activity.
- LOAD_W (N+1 cycles, counter c)
  - Cycles c=0..N-1: `w_rd_en`=1, `w_rd_addr`=N-1-c (bottom row fetched first).
  - Cycles c=1..N: `sys_weight`=`w_rd_data`.
  - `sys_new_weight`=1 only at c=1.
  - Exit to SWITCH after c=N.
- SWITCH (1 cycle): `sys_switch_in`=1, `sys_weight`=0.
- STREAM (`num_vecs` cycles)
  - `x_rd_en`=1, `x_rd_addr`=0..`num_vecs`-1, one read per cycle.
  - Returned data enters the skew stage one cycle after each read: lane i is delayed i cycles (lane 0 undelayed).
  - `sys_valid_in` is high for exactly `num_vecs` consecutive cycles, aligned with lane 0 data.
  - Lanes output 0 whenever their delayed data is not valid.
- DRAIN
  - Counts cycles with `sys_valid_out[N-1]`=1.
  - When the count equals `num_vecs`: pulse `done`, go to IDLE.
  - Skew and input issue continue until flushed; `sys_input` is all-zero before DRAIN exits.
  - Watchdog: DRAIN_MAX cycles in DRAIN without completion → pulse `timeout` and `done`, go to IDLE.
- Read addresses
  - `w_rd_addr`/`x_rd_addr` hold 0 when their read enables are low.
  - `x_rd_addr` never exceeds `num_vecs`-1; there is no wrap-around.
- `abort` (any non-IDLE state): next cycle IDLE; skew flushed to 0; all strobes low; no `done`. Takes priority over every transition in the same cycle.
- `start` while busy: ignored, with no queuing.
- `start` and `abort` together in IDLE: `abort` wins, `start` ignored.
- `rst` asserted mid-tile: immediate return to reset values; the array is assumed reset by the same `rst`.
- Counters are AW+1 bits wide so that `num_vecs`=2^AW-1 does not overflow.

Decomposition:
- Package `systolic_pkg`:
  - `N`, `DW`, `AW` constants.
  - `ctrl_state_t` enum.
  - `vec_t` typedef (array of N x DW).
- Sub-module `input_skew`: N-lane triangular delay, lane i with i registers, data plus per-lane valid, synchronous flush input.

Test Plan:
- Basic tile, `num_vecs`=4 → 16 weight reads at addresses 15..0.
  - `sys_new_weight` for exactly 1 cycle, then `sys_switch_in` for 1 cycle.
  - 4 activation reads at addresses 0..3; `sys_valid_in` high 4 cycles.
  - `sys_input[15]` carries vector 0 exactly 15 cycles after `sys_input[0]`.
  - `done` after the 4th `sys_valid_out[15]`.
- `num_vecs`=0 → `done` one cycle after `start`; `busy` stays 0; no read strobes.
- `abort` in the 3rd STREAM cycle (`num_vecs`=10) → next cycle IDLE; strobes 0; `sys_input` all 0 within 1 cycle; no `done`; a following `start` runs a full tile cleanly.
- `start` pulses during LOAD_W and DRAIN → ignored; exactly one `done` per accepted tile.
- `sys_valid_out` held 0 in DRAIN → `timeout` and `done` pulse together after 255 DRAIN cycles, then IDLE.
- `rst` low mid-LOAD_W → all outputs 0 asynchronously, state IDLE after release.
